// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receiver (16x oversampled) feeding a newest-first shift buffer
//
// Purpose: synchronizes rx, deframes DATA_BITS-N-1 frames (DATA_BITS-E-1 when
//   UART_PARITY_EN is defined) and shifts each good byte into RXBUF[0].
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx         serial input, idle high
//   RXBUF      [0:FIFO-1] byte buffer, [0] newest, [FIFO-1] oldest
//   rx_valid   one-cycle pulse on the cycle RXBUF shifts
//   rx_count   valid entries, saturates at FIFO
//   frame_err  one-cycle pulse when the stop bit samples low
//   parity_err one-cycle pulse on even-parity mismatch (0 without UART_PARITY_EN)
// Config macro: UART_PARITY_EN
module uart_rx_buffer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9_600,
  parameter int DATA_BITS = 8,
  parameter int FIFO      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic [DATA_BITS-1:0]         RXBUF [0:FIFO-1],
  output logic                         rx_valid,
  output logic [$clog2(FIFO+1)-1:0]    rx_count,
  output logic                         frame_err,
  output logic                         parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = $clog2(DIV);
  localparam int CW  = $clog2(FIFO + 1);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]           sync_q, sync_d;
  logic [DW-1:0]        div_q, div_d;
  state_t               state_q, state_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] buf_q [0:FIFO-1];
  logic [DATA_BITS-1:0] buf_d [0:FIFO-1];
  logic [CW-1:0]        count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 rx_s, tick, par_bad;

`ifdef UART_PARITY_EN
  logic par_q, par_d;
  // Even parity: data bits plus the parity bit must XOR to zero.
  assign par_bad = ^{shreg_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  assign rx_s = sync_q[1];
  assign tick = (div_q == DW'(DIV - 1));

  always_comb begin
    sync_d  = {sync_q[0], rx};
    div_d   = tick ? '0 : div_q + DW'(1);
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    buf_d   = buf_q;
    count_d = count_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tcnt_d  = '0;
          end
        end
        S_START: begin
          // Re-check mid start bit so short low glitches are ignored.
          if (tcnt_q == 4'd7) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        S_DATA: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shreg_d[bcnt_q] = rx_s;
            bcnt_d          = bcnt_q + BW'(1);
            if (bcnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            par_d   = rx_s;
            state_d = S_STOP;
          end
        end
`endif
        S_STOP: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            // Back to IDLE mid stop bit; the next start edge is caught on a later tick.
            state_d = S_IDLE;
            if (!rx_s) begin
              ferr_d = 1'b1;
            end else if (par_bad) begin
              perr_d = 1'b1;
            end else begin
              valid_d  = 1'b1;
              buf_d[0] = shreg_q;
              for (int i = 1; i < FIFO; i++) buf_d[i] = buf_q[i-1];
              if (count_q != CW'(FIFO)) count_d = count_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      div_q   <= '0;
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
      for (int i = 0; i < FIFO; i++) buf_q[i] <= '0;
    end else begin
      sync_q  <= sync_d;
      div_q   <= div_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
      buf_q   <= buf_d;
    end
  end

  assign RXBUF      = buf_q;
  assign rx_valid   = valid_q;
  assign rx_count   = count_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule
